mips_data_mem: RTL
==================

// Module: mips_data_mem
// PURPOSE
//  Memory-side responder for the mips_core data port (mem_addr / mem_data_in / mem_data_out / mem_write_en).
//  - Byte-addressed, 4-byte-wide data memory.
//  - Adds a mem_req/mem_ready handshake with fixed, parameterised latency, so the core and caches can be tested against slow memory.
//  - Sits between mips_core and the testbench top; instruction memory is separate.
// PARAMETERS
//  ADDR_BITS   16   byte-address width of storage; depth = 2**ADDR_BITS bytes
//  LATENCY     4    cycles from request accept to mem_ready pulse; legal range 1..255
//  START_ADDR  0    byte address mapped to storage byte 0
// PORTS
//  clk           in   1      rising-edge clock
//  rst_b         in   1      asynchronous active-low reset
//  mem_req       in   1      core requests an access; sampled only in IDLE
//  mem_addr      in   32     byte address of byte 0 of the access
//  mem_write_en  in   1      1 = write, 0 = read; latched with mem_req
//  mem_data_in   in   8x4    [0:3] bytes from core; [0] goes to mem_addr+0
//  mem_data_out  out  8x4    [0:3] read data; [0] comes from mem_addr+0
//  mem_ready     out  1      one-cycle completion pulse
//  halted        in   1      core halted; no new requests are accepted
// BEHAVIOUR
//  - Reset (rst_b=0, async):
//    - state=IDLE, counter=0, mem_ready=0, mem_data_out all 8'h00.
//    - Storage contents are not reset.
//    - Reset during BUSY aborts the transaction; no write occurs.
//  - FSM IDLE -> BUSY -> DONE -> IDLE.
//    - IDLE: if mem_req && !halted, latch addr/we/data, load counter=LATENCY-1, go to BUSY.
//    - BUSY: if counter==0, go to DONE; else decrement the counter.
//    - DONE: perform the access, assert mem_ready for exactly this cycle, then return to IDLE unconditionally.
//  - Request-to-ready timing:
//    - Request accepted at edge N; mem_ready is high in cycle N+LATENCY.
//    - Minimum spacing between back-to-back requests is LATENCY+2 cycles; a held mem_req is re-accepted in IDLE.
//  - Write, in DONE:
//    - Storage[off+i] <= latched data[i] for i=0..3.
//    - mem_data_out is unchanged.
//  - Read, in DONE:
//    - mem_data_out[i] <= storage[off+i].
//    - The registered value is valid while mem_ready=1 and held until the next read completes.
//  - off = (addr - START_ADDR) mod 2**ADDR_BITS, in 32-bit arithmetic.
//    - Each off+i also wraps mod 2**ADDR_BITS, so an access at the top byte wraps to byte 0.
//  - Inputs changing during BUSY/DONE are ignored; only latched values are used.
//  - mem_req while not IDLE is ignored and not queued.
//  - halted rising during BUSY: the current transaction completes normally; halted then blocks acceptance in IDLE.
//  - Simultaneous mem_req and halted in IDLE: the request is not accepted.
// CONFIGURATION
//  MEM_ALIGN_CHECK_EN
//   - Defined:
//     - Adds output port mem_misaligned (1 bit, reset 0).
//     - If latched addr[1:0]!=0, the transaction still runs the full latency.
//     - In DONE: mem_ready=1, mem_misaligned=1 for that cycle, no write, mem_data_out unchanged.
//     - mem_misaligned is otherwise 0.
//   - Undefined: no such port; unaligned addresses access 4 consecutive bytes with wrap as above.
// TESTING
//  1. Reset, LATENCY=4: write addr=0x100, data {11,22,33,44} at edge 0.
//     -> mem_ready=1 only in cycle 4; storage[0x100..0x103]=11,22,33,44.
//  2. Read 0x100 after test 1.
//     -> mem_ready pulses 4 cycles after accept; mem_data_out={11,22,33,44}; values held after the pulse.
//  3. mem_req held high continuously.
//     -> accepts spaced LATENCY+2=6 cycles apart; mem_req pulses during BUSY are ignored.
//  4. Write at byte 0xFFFE (ADDR_BITS=16), data {A,B,C,D}.
//     -> storage[0xFFFE]=A, [0xFFFF]=B, [0x0000]=C, [0x0001]=D.
//  5. Write accepted, then rst_b=0 for 1 cycle mid-BUSY.
//     -> mem_ready stays 0; the target bytes keep their prior values; the next request is accepted in IDLE.
//  6. halted=1 during BUSY, then a new mem_req.
//     -> the current transaction completes with a ready pulse; the new request is never accepted.
//     -> With MEM_ALIGN_CHECK_EN: a write to 0x102 gives mem_misaligned=1 with the ready pulse and storage is unchanged.

Source files
------------

// File: rtl/mips_data_mem.sv
// Byte-addressed 4-byte data memory with a req/ready handshake and fixed latency.
// Optional `MEM_ALIGN_CHECK_EN adds mem_misaligned and suppresses unaligned accesses.
//
// state  | meaning
// S_IDLE | waiting for mem_req with halted low
// S_BUSY | counting down the latched latency
// S_DONE | mem_ready high; access already applied at the entry edge
module mips_data_mem #(
    parameter int          ADDR_BITS  = 16,
    parameter int          LATENCY    = 4,
    parameter logic [31:0] START_ADDR = 32'h0
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            mem_req,
    input  logic [31:0]     mem_addr,
    input  logic            mem_write_en,
    input  logic [0:3][7:0] mem_data_in,
    output logic [0:3][7:0] mem_data_out,
    output logic            mem_ready,
`ifdef MEM_ALIGN_CHECK_EN
    output logic            mem_misaligned,
`endif
    input  logic            halted
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [7:0]             r_cnt;
    logic [ADDR_BITS-1:0]   r_off;
    logic                   r_we;
    logic                   r_bad;
    logic [0:3][7:0]        r_data;
    logic [0:3][7:0]        r_data_out;
    logic                   r_ready;
    logic                   r_misaligned;
    logic [7:0]             r_mem [0:DEPTH-1];

    logic                   w_accept;
    logic                   w_access;
    logic                   w_req_bad;
    logic [31:0]            w_off_in;
    logic                   w_unused_hi;
    logic [ADDR_BITS-1:0]   w_idx [0:3];

    assign w_accept    = (r_state == S_IDLE) && mem_req && !halted;
    assign w_access    = (r_state == S_BUSY) && (r_cnt == 8'd0);
    assign w_off_in    = mem_addr - START_ADDR;
    assign w_unused_hi = ^w_off_in[31:ADDR_BITS];

`ifdef MEM_ALIGN_CHECK_EN
    assign w_req_bad = (mem_addr[1:0] != 2'b00);
`else
    assign w_req_bad = 1'b0;
`endif

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_idx[i] = r_off + ADDR_BITS'(i);
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next_state = S_BUSY;
            S_BUSY:  if (r_cnt == 8'd0) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Access is applied on the edge entering DONE so read data is valid with mem_ready.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state      <= S_IDLE;
            r_cnt        <= 8'd0;
            r_off        <= '0;
            r_we         <= 1'b0;
            r_bad        <= 1'b0;
            r_data       <= '0;
            r_data_out   <= '0;
            r_ready      <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_ready      <= w_access;
            r_misaligned <= w_access && r_bad;
            if (w_accept) begin
                r_off  <= w_off_in[ADDR_BITS-1:0];
                r_we   <= mem_write_en;
                r_bad  <= w_req_bad;
                r_data <= mem_data_in;
                r_cnt  <= 8'(LATENCY - 1);
            end else if ((r_state == S_BUSY) && (r_cnt != 8'd0)) begin
                r_cnt <= r_cnt - 8'd1;
            end
            if (w_access && !r_we && !r_bad) begin
                for (int i = 0; i < 4; i++) begin
                    r_data_out[i] <= r_mem[w_idx[i]];
                end
            end
        end
    end

    // Storage has no reset; contents survive rst_b.
    always_ff @(posedge clk) begin
        if (w_access && r_we && !r_bad) begin
            for (int i = 0; i < 4; i++) begin
                r_mem[w_idx[i]] <= r_data[i];
            end
        end
    end

    assign mem_data_out = r_data_out;
    assign mem_ready    = r_ready;
`ifdef MEM_ALIGN_CHECK_EN
    assign mem_misaligned = r_misaligned;
`endif

endmodule
